// File: rtl/host_mem_axi_responder.sv
// host_mem_axi_responder
//   AXI4 slave backed by an on-chip RAM. Acts as the far end of the AFU
//   host-memory master port in loopback builds and simulation benches.
//   It stores write bursts, returns read bursts, and generates B/R responses.
//
// Ports
//   clk, areset_n          single clock, asynchronous active-low reset
//   s_axi_aw*              write address (id, addr, len, size, burst, user)
//   s_axi_w*               write data (data, strb, last)
//   s_axi_b*               write response (id, resp, user echoed from AW)
//   s_axi_ar*              read address (id, addr, len, size, burst, user)
//   s_axi_r*               read data (id, data, resp, last, user echoed from AR)
//
// Optional feature
//   HOST_MEM_RESP_BACKPRESSURE_EN : a 16-bit LFSR inserts pseudo-random stall
//   cycles. During a stall cycle awready, arready and wready are held low and
//   no new rvalid is raised.
//
// Behaviour notes
//   - The beat index is taken from the address bits just above the byte
//     offset. It wraps modulo the RAM depth.
//   - A size other than the full bus width, or a non-INCR burst, gives SLVERR.
//     Errored writes leave the RAM untouched, and errored reads return zero
//     data.
//   - Read path: a RAM with one cycle of latency feeds a 2-entry output buffer.
module host_mem_axi_responder #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned DATA_WIDTH     = 512,
  parameter int unsigned ID_WIDTH       = 9,
  parameter int unsigned USER_WIDTH     = 8,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    areset_n,
  // write address
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic [USER_WIDTH-1:0]   s_axi_awuser,
  // write data
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  // write response
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [USER_WIDTH-1:0]   s_axi_buser,
  // read address
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic [USER_WIDTH-1:0]   s_axi_aruser,
  // read data
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [USER_WIDTH-1:0]   s_axi_ruser
);

  localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned IDX_LSB     = $clog2(STRB_WIDTH);
  localparam int unsigned DEPTH       = 1 << MEM_DEPTH_LOG2;
  localparam logic [2:0]  FULL_SIZE   = 3'(IDX_LSB);
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

  // Address bits outside the index field are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr, s_axi_araddr, LFSR_SEED};

  // awready and arready stay low until the first clock after reset release.
  logic rst_done;
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rst_done <= 1'b0;
    else           rst_done <= 1'b1;
  end

  logic stall;

  // ---------------- write channel ----------------
  w_state_t              w_state, w_state_nxt;
  idx_t                  w_idx;
  logic [7:0]            w_len;
  logic [8:0]            w_beat;
  logic                  w_err;
  logic [ID_WIDTH-1:0]   w_id;
  logic [USER_WIDTH-1:0] w_user;
  logic                  aw_fire, w_fire, ram_we;

  always_comb begin
    w_state_nxt   = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = rst_done && !stall;
        if (s_axi_awvalid && rst_done && !stall) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !stall;
        if (s_axi_wvalid && !stall && s_axi_wlast) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign aw_fire = s_axi_awvalid && s_axi_awready;
  assign w_fire  = s_axi_wvalid && s_axi_wready;

  // Beats past len, and a beat carrying a premature wlast, are discarded.
  assign ram_we = w_fire && !w_err && (w_beat <= {1'b0, w_len}) &&
                  !(s_axi_wlast && (w_beat != {1'b0, w_len}));

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_err   <= 1'b0;
      w_id    <= '0;
      w_user  <= '0;
    end else begin
      w_state <= w_state_nxt;
      if (aw_fire) begin
        w_id   <= s_axi_awid;
        w_user <= s_axi_awuser;
        w_idx  <= s_axi_awaddr[IDX_LSB +: MEM_DEPTH_LOG2];
        w_len  <= s_axi_awlen;
        w_beat <= '0;
        w_err  <= (s_axi_awsize != FULL_SIZE) || (s_axi_awburst != BURST_INCR);
      end else if (w_fire) begin
        w_idx <= w_idx + 1'b1;
        // Saturate at len+1 so overlong bursts cannot wrap the counter.
        if (w_beat <= {1'b0, w_len}) w_beat <= w_beat + 1'b1;
        if (s_axi_wlast && (w_beat != {1'b0, w_len})) w_err <= 1'b1;
      end
    end
  end

  assign s_axi_bid   = w_id;
  assign s_axi_buser = w_user;
  assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  r_state_t              r_state, r_state_nxt;
  idx_t                  r_idx;
  logic [7:0]            r_len;
  logic [8:0]            r_issue;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;
  logic                  ar_fire, rd_issue, rd_inflight, ram_q_last, r_pop;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic                  fifo_last [2];
  logic                  fifo_rd_ptr, fifo_wr_ptr;
  logic [1:0]            fifo_count;
  logic [1:0]            r_occ;

  always_comb begin
    r_state_nxt   = r_state;
    s_axi_arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = rst_done && !stall;
        if (s_axi_arvalid && rst_done && !stall) r_state_nxt = R_BURST;
      end
      R_BURST: begin
        if (r_pop && fifo_last[fifo_rd_ptr]) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign ar_fire = s_axi_arvalid && s_axi_arready;
  assign r_pop   = s_axi_rvalid && s_axi_rready;

  // Credit check: buffered beats plus the one in the RAM pipeline must never
  // exceed the 2 buffer slots. This also counts a slot freed by a pop in
  // the same cycle.
  assign r_occ    = fifo_count + {1'b0, rd_inflight};
  assign rd_issue = (r_state == R_BURST) && (r_issue <= {1'b0, r_len}) &&
                    ((r_occ - {1'b0, r_pop}) < 2'd2);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state     <= R_IDLE;
      r_idx       <= '0;
      r_len       <= '0;
      r_issue     <= '0;
      r_err       <= 1'b0;
      r_id        <= '0;
      r_user      <= '0;
      rd_inflight <= 1'b0;
      ram_q_last  <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_count  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      r_state     <= r_state_nxt;
      rd_inflight <= rd_issue;
      if (ar_fire) begin
        r_id    <= s_axi_arid;
        r_user  <= s_axi_aruser;
        r_idx   <= s_axi_araddr[IDX_LSB +: MEM_DEPTH_LOG2];
        r_len   <= s_axi_arlen;
        r_issue <= '0;
        r_err   <= (s_axi_arsize != FULL_SIZE) || (s_axi_arburst != BURST_INCR);
      end else if (rd_issue) begin
        r_idx      <= r_idx + 1'b1;
        r_issue    <= r_issue + 1'b1;
        ram_q_last <= (r_issue == {1'b0, r_len});
      end
      if (rd_inflight) begin
        fifo_data[fifo_wr_ptr] <= r_err ? '0 : ram_q;
        fifo_last[fifo_wr_ptr] <= ram_q_last;
        fifo_wr_ptr            <= ~fifo_wr_ptr;
      end
      if (r_pop) fifo_rd_ptr <= ~fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, rd_inflight} - {1'b0, r_pop};
    end
  end

  assign s_axi_rdata = fifo_data[fifo_rd_ptr];
  assign s_axi_rlast = fifo_last[fifo_rd_ptr];
  assign s_axi_rid   = r_id;
  assign s_axi_ruser = r_user;
  assign s_axi_rresp = r_err ? RESP_SLVERR : RESP_OKAY;

  // ---------------- RAM ----------------
  // A read and a write of the same index in the same cycle return the
  // pre-write contents.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
    if (rd_issue) ram_q <= mem[r_idx];
  end

  // ---------------- backpressure ----------------
`ifdef HOST_MEM_RESP_BACKPRESSURE_EN
  logic [15:0] lfsr;
  logic        rvalid_held;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      lfsr        <= LFSR_SEED;
      rvalid_held <= 1'b0;
    end else begin
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rvalid_held <= s_axi_rvalid && !s_axi_rready;
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
  // A stall may delay raising rvalid but must never retract a presented beat.
  assign s_axi_rvalid = (fifo_count != 2'd0) && (!stall || rvalid_held);
`else
  assign stall        = 1'b0;
  assign s_axi_rvalid = (fifo_count != 2'd0);
`endif

endmodule

// File: tb/tb_host_mem_axi_responder.sv
`timescale 1ns/1ps
module tb_host_mem_axi_responder;

  localparam int unsigned AW    = 64;
  localparam int unsigned DW    = 512;
  localparam int unsigned IW    = 9;
  localparam int unsigned UW    = 8;
  localparam int unsigned DL    = 10;
  localparam int unsigned SB    = DW / 8;
  localparam int unsigned DEPTH = 1 << DL;
  localparam int unsigned BOUND = 200;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          awvalid, awready;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic [UW-1:0] awuser;
  logic          wvalid, wready, wlast;
  logic [DW-1:0] wdata;
  logic [SB-1:0] wstrb;
  logic          bvalid, bready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic [UW-1:0] buser;
  logic          arvalid, arready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic [UW-1:0] aruser;
  logic          rvalid, rready, rlast;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [UW-1:0] ruser;

  host_mem_axi_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW),
    .MEM_DEPTH_LOG2(DL), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .areset_n(areset_n),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
    .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awuser(awuser),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
    .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid),
    .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
    .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_aruser(aruser),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser)
  );

  always #5 clk = ~clk;

  // Reference memory: one entry per beat index, updated by the AXI write rules.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] wq_data [$];
  logic [SB-1:0] wq_strb [$];
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic int unsigned index_of(input logic [AW-1:0] addr);
    return int'((addr >> 6) % DEPTH);
  endfunction

  // Writes a burst using the queued beats. wlast goes on the final queued beat.
  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst,
                          input logic [IW-1:0] id, input logic [UW-1:0] user,
                          input int unsigned bdelay);
    int unsigned nb, base, cyc;
    bit          bad;
    logic [1:0]  exp_resp;
    nb   = wq_data.size();
    base = index_of(addr);
    bad  = (size != 3'd6) || (burst != 2'b01);
    awvalid = 1'b1; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    awid = id; awuser = user;
    cyc = 0;
    while (!awready && cyc < BOUND) begin tick(); cyc++; end
    check_eq("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int unsigned i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = wq_data[i]; wstrb = wq_strb[i]; wlast = (i == nb - 1);
      cyc = 0;
      while (!wready && cyc < BOUND) begin tick(); cyc++; end
      check_eq("w_ready", wready, 1);
      tick();
      if (!bad && i <= len && !(i == nb - 1 && i != len)) begin
        for (int unsigned b = 0; b < SB; b++)
          if (wq_strb[i][b]) ref_mem[(base + i) % DEPTH][b*8 +: 8] = wq_data[i][b*8 +: 8];
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    exp_resp = (bad || (nb - 1 != len)) ? 2'b10 : 2'b00;
    repeat (bdelay) tick();
    bready = 1'b1;
    cyc = 0;
    while (!bvalid && cyc < BOUND) begin tick(); cyc++; end
    check_eq("b_valid", bvalid, 1);
    check_eq("b_id", bid, id);
    check_eq("b_user", buser, user);
    check_eq("b_resp", bresp, exp_resp);
    tick();
    bready = 1'b0;
    wq_data.delete();
    wq_strb.delete();
  endtask

  // mode 0: rready always 1; mode 1: rready 1,0,0 repeating; mode 2: random.
  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst,
                         input logic [IW-1:0] id, input logic [UW-1:0] user,
                         input int unsigned mode, input bit chk_timing);
    int unsigned   base, cyc, beat, lat, k, first_cyc, last_cyc;
    bit            bad, seen, stalled;
    logic [DW-1:0] held_data;
    logic          held_last;
    logic [DW-1:0] exp_data;
    base = index_of(addr);
    bad  = (size != 3'd6) || (burst != 2'b01);
    arvalid = 1'b1; araddr = addr; arlen = len; arsize = size; arburst = burst;
    arid = id; aruser = user;
    cyc = 0;
    while (!arready && cyc < BOUND) begin tick(); cyc++; end
    check_eq("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
    beat = 0; cyc = 0; lat = 0; k = 0; seen = 0; stalled = 0;
    first_cyc = 0; last_cyc = 0; held_data = '0; held_last = 1'b0;
    while (beat <= len && cyc < 4000) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = (k % 3 == 0);
        default: rready = 1'($urandom_range(0, 1));
      endcase
      if (stalled) begin
        check_eq("r_hold_valid", rvalid, 1);
        check_eq("r_hold_data", rdata, held_data);
        check_eq("r_hold_last", rlast, held_last);
      end
      if (rvalid) begin
        if (!seen) begin
          seen = 1;
          first_cyc = cyc;
          if (chk_timing) check_eq("r_first_latency", lat, 2);
        end
        if (rready) begin
          exp_data = bad ? '0 : ref_mem[(base + beat) % DEPTH];
          check_eq("r_data", rdata, exp_data);
          check_eq("r_resp", rresp, bad ? 2'b10 : 2'b00);
          check_eq("r_id", rid, id);
          check_eq("r_user", ruser, user);
          check_eq("r_last", rlast, beat == len);
          last_cyc = cyc;
          beat++;
          stalled = 0;
        end else begin
          stalled = 1; held_data = rdata; held_last = rlast;
        end
      end else if (!seen) begin
        lat++;
      end
      tick();
      cyc++; k++;
    end
    rready = 1'b0;
    check_eq("r_beat_count", beat, len + 1);
    if (chk_timing) begin
      check_eq("r_back_to_back", last_cyc - first_cyc, len);
      check_eq("ar_ready_after", arready, 1);
    end
  endtask

  task automatic push_beats(input int unsigned n, input bit full_strb);
    for (int unsigned i = 0; i < n; i++) begin
      wq_data.push_back(rand_data());
      wq_strb.push_back(full_strb ? {SB{1'b1}} : {$urandom, $urandom});
    end
  endtask

  initial begin
    logic [DW-1:0] ones;
    bit            timing;
    int unsigned   n_rand, cyc;
`ifdef HOST_MEM_RESP_BACKPRESSURE_EN
    timing = 0;
    n_rand = 1000;
`else
    timing = 1;
    n_rand = 200;
`endif
    areset_n = 1'b0;
    awvalid = 0; awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awuser = '0;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0; bready = 0;
    arvalid = 0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; aruser = '0;
    rready = 0;
    repeat (3) tick();
    check_eq("rst_awready", awready, 0);
    check_eq("rst_arready", arready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    areset_n = 1'b1;
    #1;
    check_eq("rel_awready_early", awready, 0);
    tick();
    if (timing) begin
      check_eq("rel_awready", awready, 1);
      check_eq("rel_arready", arready, 1);
    end

    // Fill indices 0..63 so every later read covers written locations.
    push_beats(64, 1);
    do_write(64'h0, 8'd63, 3'd6, 2'b01, 9'h1FF, 8'h11, 0);

    // Basic 4-beat burst at 0x40.
    for (int unsigned i = 0; i < 4; i++) begin
      wq_data.push_back(DW'(8'hA0 + i));
      wq_strb.push_back({SB{1'b1}});
    end
    do_write(64'h40, 8'd3, 3'd6, 2'b01, 9'h0A5, 8'h5A, 2);
    check_eq("model_a2", ref_mem[3], DW'(8'hA2));
    do_read(64'h40, 8'd3, 3'd6, 2'b01, 9'h0A5, 8'hC3, 0, timing);

    // Partial strobe over all-ones.
    ones = '1;
    wq_data.push_back(ones); wq_strb.push_back({SB{1'b1}});
    do_write(64'd10 * 64, 8'd0, 3'd6, 2'b01, 9'h003, 8'h01, 0);
    wq_data.push_back(DW'(32'h12345678)); wq_strb.push_back(SB'(64'h0F));
    do_write(64'd10 * 64, 8'd0, 3'd6, 2'b01, 9'h004, 8'h02, 1);
    check_eq("model_strb", ref_mem[10], {ones[DW-1:32], 32'h12345678});
    do_read(64'd10 * 64, 8'd0, 3'd6, 2'b01, 9'h005, 8'h03, 0, 0);

    // Early wlast: error response, beat discarded. Then a FIXED read.
    push_beats(1, 1);
    do_write(64'd20 * 64, 8'd1, 3'd6, 2'b01, 9'h006, 8'h04, 0);
    do_read(64'd20 * 64, 8'd0, 3'd6, 2'b01, 9'h007, 8'h05, 0, 0);
    do_read(64'h40, 8'd3, 3'd6, 2'b00, 9'h008, 8'h06, 0, 0);

    // Bad size on write and read.
    push_beats(2, 1);
    do_write(64'd30 * 64, 8'd1, 3'd5, 2'b01, 9'h009, 8'h07, 0);
    do_read(64'd30 * 64, 8'd1, 3'd5, 2'b01, 9'h00A, 8'h08, 0, 0);
    do_read(64'd30 * 64, 8'd1, 3'd6, 2'b01, 9'h00B, 8'h09, 0, 0);

    // Index wrap from the top of RAM; high address bits ignored.
    push_beats(2, 1);
    do_write(64'hABCD_0000_0000_FFC0, 8'd1, 3'd6, 2'b01, 9'h00C, 8'h0A, 0);
    do_read(64'h0000_1234_0000_FFC0, 8'd1, 3'd6, 2'b01, 9'h00D, 8'h0B, 0, 0);
    do_read(64'h0, 8'd0, 3'd6, 2'b01, 9'h00E, 8'h0C, 0, 0);

    // rready pattern 1,0,0 on an 8-beat read.
    do_read(64'h0, 8'd7, 3'd6, 2'b01, 9'h00F, 8'h0D, 1, 0);

    // Randomized bursts.
    for (int unsigned t = 0; t < n_rand; t++) begin
      logic [AW-1:0] a;
      logic [7:0]    l;
      logic [2:0]    sz;
      logic [1:0]    bu;
      int unsigned   base, nb;
      base = $urandom_range(0, 56);
      l    = 8'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      a[15:6] = 10'(base);
      sz   = ($urandom_range(0, 19) == 0) ? 3'd5 : 3'd6;
      bu   = ($urandom_range(0, 19) == 0) ? 2'b10 : 2'b01;
      if ($urandom_range(0, 1) == 0) begin
        nb = l + 1;
        if ($urandom_range(0, 9) == 0) nb = $urandom_range(1, l + 2);
        push_beats(nb, $urandom_range(0, 1) == 0);
        do_write(a, l, sz, bu, 9'($urandom), 8'($urandom), $urandom_range(0, 2));
      end else begin
        do_read(a, l, sz, bu, 9'($urandom), 8'($urandom), 2, 0);
      end
    end

    // Reset in the middle of a read burst.
    arvalid = 1'b1; araddr = 64'h0; arlen = 8'd7; arsize = 3'd6; arburst = 2'b01;
    arid = 9'h010; aruser = 8'h0E;
    cyc = 0;
    while (!arready && cyc < BOUND) begin tick(); cyc++; end
    tick();
    arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) tick();
    areset_n = 1'b0;
    #1;
    check_eq("mid_rst_rvalid", rvalid, 0);
    check_eq("mid_rst_arready", arready, 0);
    check_eq("mid_rst_bvalid", bvalid, 0);
    rready = 1'b0;
    repeat (2) tick();
    areset_n = 1'b1;
    #1;
    check_eq("mid_rel_rvalid", rvalid, 0);
    cyc = 0;
    tick();
    while (!arready && cyc < 20) begin tick(); cyc++; end
    check_eq("mid_rel_arready", arready, 1);
    if (timing) check_eq("mid_rel_arready_cycle", cyc, 0);
    check_eq("mid_rel_rvalid2", rvalid, 0);
    do_read(64'h40, 8'd3, 3'd6, 2'b01, 9'h011, 8'h0F, 0, timing);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
